// File: rtl/rom_loader.sv
// Loads a framed byte stream (LEN_HI, LEN_LO, payload, CHK) into the ROM init port,
// verifying an additive checksum and reporting done/error with sticky flags.
module rom_loader #(
    parameter int ADDR_W    = 14,
    parameter int DEPTH     = 16384,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mode,
    output logic [ADDR_W-1:0] sw_addr,
    output logic [7:0]        sw_din,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    localparam int CW = ADDR_W + 1;
    localparam int LW = 17;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] BASE_L    = ADDR_W'(BASE_ADDR);
    localparam logic [LW-1:0]     DEPTH_L   = LW'(DEPTH);
    localparam logic [TW-1:0]     TIMER_END = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PAYLOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_n;
    logic              ready_q, ready_n;
    logic              mode_q, mode_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        din_q, din_n;
    logic              done_q, done_n;
    logic              error_q, error_n;
    logic [CW-1:0]     count_q, count_n;
    logic [7:0]        sum_q, sum_n;
    logic [7:0]        len_hi_q, len_hi_n;
    logic [15:0]       len_q, len_n;
    logic [TW-1:0]     timer_q, timer_n;

    logic              xfer;
    logic              active;
    logic              timed_out;
    logic [15:0]       len_rx;
    logic [CW-1:0]     count_inc;
    logic [7:0]        chk_sum;

    always_comb begin
        xfer      = s_valid && ready_q;
        active    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);
        timed_out = active && !xfer && (timer_q == TIMER_END);
        len_rx    = {len_hi_q, s_data};
        count_inc = count_q + CW'(1);
        chk_sum   = sum_q + s_data;
    end

    always_comb begin
        state_n  = state_q;
        mode_n   = mode_q;
        addr_n   = addr_q;
        din_n    = din_q;
        done_n   = done_q;
        error_n  = error_q;
        count_n  = count_q;
        sum_n    = sum_q;
        len_hi_n = len_hi_q;
        len_n    = len_q;
        timer_n  = '0;

        if (active) begin
            timer_n = xfer ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n = S_LEN_HI;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    count_n = '0;
                    sum_n   = '0;
                    addr_n  = BASE_L;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_n = s_data;
                    state_n  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_n = len_rx;
                    // A zero or oversized length is rejected before any ROM write.
                    if ((len_rx == 16'd0) || ({1'b0, len_rx} > DEPTH_L)) begin
                        state_n = S_ERR;
                        error_n = 1'b1;
                    end else begin
                        state_n = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    din_n   = s_data;
                    addr_n  = BASE_L + count_q[ADDR_W-1:0];
                    mode_n  = 1'b1;
                    count_n = count_inc;
                    sum_n   = chk_sum;
                    if (LW'(count_inc) == {1'b0, len_q}) begin
                        state_n = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (xfer) begin
                    mode_n = 1'b0;
                    if (chk_sum == 8'h00) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_ERR;
                        error_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // An idle stream during a load overrides whatever the state decode chose.
        if (timed_out) begin
            state_n = S_ERR;
            error_n = 1'b1;
            mode_n  = 1'b0;
        end

        ready_n = (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                  (state_n == S_PAYLOAD) || (state_n == S_CHK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            mode_q   <= 1'b0;
            addr_q   <= BASE_L;
            din_q    <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
            sum_q    <= '0;
            len_hi_q <= '0;
            len_q    <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_n;
            ready_q  <= ready_n;
            mode_q   <= mode_n;
            addr_q   <= addr_n;
            din_q    <= din_n;
            done_q   <= done_n;
            error_q  <= error_n;
            count_q  <= count_n;
            sum_q    <= sum_n;
            len_hi_q <= len_hi_n;
            len_q    <= len_n;
            timer_q  <= timer_n;
        end
    end

    assign s_ready    = ready_q;
    assign busy       = ready_q;
    assign mode       = mode_q;
    assign sw_addr    = addr_q;
    assign sw_din     = din_q;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = count_q;

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Initialisation writer for the virtual platform's 16 KiB byte-wide ROM, which has an init port (mode, sw_addr, sw_din).
- Accepts a framed byte stream from the host/debug side over a valid/ready handshake.
- Drives the ROM init port to write the image sequentially, verifies a checksum, and reports done or error.
- Sits between the host byte source (UART/JTAG bridge) and the ROM. While mode=1 the ROM ignores CPU reads and writes.

Parameters:
- ADDR_W, 14, ROM address width.
- DEPTH, 16384, ROM size in bytes; maximum accepted image length.
- BASE_ADDR, 0, first ROM address written.
- TIMEOUT, 1000000, idle cycles allowed between bytes during a load before the load aborts.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load when idle, done or error.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a byte; transfer happens when s_valid && s_ready on a posedge.
- mode  out  1  ROM init enable; the ROM writes sw_din to sw_addr on every clock while it is high.
- sw_addr  out  ADDR_W  ROM init address.
- sw_din  out  8  ROM init data.
- busy  out  1  load in progress.
- done  out  1  last load completed with a good checksum; sticky.
- error  out  1  last load failed; sticky.
- byte_count  out  ADDR_W+1  payload bytes written in the current or last load.

Behaviour:
- Frame format: LEN_HI, LEN_LO (16-bit big-endian payload length), then LEN payload bytes, then CHK. The frame is valid when (sum of payload + CHK) mod 256 == 0.
- States: IDLE, LEN_HI, LEN_LO, PAYLOAD, CHK, DONE, ERR.
- Reset (rst=1 at posedge) puts the block in IDLE with mode=0, sw_addr=BASE_ADDR, sw_din=0, s_ready=0, busy=0, done=0, error=0, byte_count=0. Internal sum, length and timeout counters are cleared.
- Reset mid-load aborts immediately and mode drops the next cycle. The ROM contents are left partially written.
- IDLE/DONE/ERR -> LEN_HI on start. This transition clears done, error, byte_count and sum, and sets sw_addr=BASE_ADDR. start is ignored in every other state.
- s_ready is registered and equals 1 exactly in LEN_HI, LEN_LO, PAYLOAD and CHK. busy has the same value.
- LEN_HI: capture the high byte, go to LEN_LO.
- LEN_LO: capture the low byte.
  - If LEN==0 or LEN>DEPTH, go to ERR without consuming further bytes.
  - Otherwise go to PAYLOAD.
- PAYLOAD, per accepted byte b:
  - sw_din<=b, sw_addr<=BASE_ADDR+byte_count (mod 2^ADDR_W, so wrap-around is allowed when BASE_ADDR≠0), mode<=1.
  - byte_count<=byte_count+1, sum<=sum+b (8-bit wrap).
  - After byte number LEN, go to CHK.
  - The ROM write lands one clock after acceptance.
- mode behaviour:
  - mode rises together with the first payload update, so the ROM never sees a stale address.
  - Between accepted bytes, sw_addr and sw_din hold, so repeated ROM writes are idempotent.
  - mode stays 1 through CHK and drops on entry to DONE or ERR.
- CHK: accept one byte c.
  - If (sum+c)[7:0]==0, go to DONE (done=1).
  - Otherwise go to ERR (error=1).
- Timeout: in LEN_HI through CHK, a counter increments on each cycle with no accepted byte and clears on each transfer. When it reaches TIMEOUT, go to ERR.
- DONE and ERR hold their flags until start or rst. done and error are never both 1.
- Stall: when s_valid=0, no state change occurs except the timeout count.
- Throughput: one byte per cycle when s_valid is held high.
- Error inputs: bytes presented in IDLE/DONE/ERR are not accepted (s_ready=0).

Test Plan:
- Reset then start, stream 00 03 11 22 33 9A at 1 byte/cycle -> ROM[0..2]=11,22,33; done=1, error=0, byte_count=3; mode=0 the cycle after CHK is accepted; s_ready=0 after.
- Same frame with CHK=9B -> ROM[0..2] written; error=1, done=0, mode=0.
- Frame 00 00, then frame 40 01 -> each goes to ERR right after LEN_LO, with byte_count=0 and mode never asserted.
- Payload 00 02 AA BB 9B with s_valid toggling 1/0 every cycle -> sw_addr/sw_din stable during gaps, ROM[0]=AA, ROM[1]=BB, done=1.
- TIMEOUT=16: send 00 04 01 then stop -> error=1 exactly 16 cycles after the last transfer, mode=0, byte_count=1. A following start plus a good frame gives done=1.
- Assert rst during PAYLOAD after 2 bytes -> next cycle all outputs at reset values; start during PAYLOAD has no effect.
